// File: rtl/quick_spi_arbiter.sv
// Round-robin arbiter sharing one quick_spi master between several clients.
// Grants are held until spi_done or a watchdog expiry, then a fixed idle gap follows.
module quick_spi_arbiter #(
    parameter int unsigned NUMBER_OF_REQUESTERS = 4,
    parameter int unsigned NUMBER_OF_SLAVES     = 2,
    parameter int unsigned TIMEOUT_CYCLES       = 4096,
    parameter int unsigned GAP_CYCLES           = 2
) (
    input  logic                                              clk,
    input  logic                                              reset_n,
    input  logic [NUMBER_OF_REQUESTERS-1:0]                   req,
    input  logic [NUMBER_OF_REQUESTERS*NUMBER_OF_SLAVES-1:0]  req_slave,
    output logic [NUMBER_OF_REQUESTERS-1:0]                   gnt,
    output logic [NUMBER_OF_REQUESTERS-1:0]                   done,
    output logic [NUMBER_OF_REQUESTERS-1:0]                   timeout,
    output logic                                              spi_start_transaction,
    output logic [NUMBER_OF_SLAVES-1:0]                       spi_slave,
    input  logic                                              spi_done,
    output logic                                              busy
);

    localparam int unsigned N     = NUMBER_OF_REQUESTERS;
    localparam int unsigned S     = NUMBER_OF_SLAVES;
    localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, START, WAIT_DONE, GAP} state_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [N-1:0]     done_q, done_d;
    logic [N-1:0]     timeout_q, timeout_d;
    logic             start_q, start_d;
    logic [S-1:0]     slave_q, slave_d;
    logic             busy_q, busy_d;

    logic             found;
    logic [PTR_W-1:0] sel;
    logic [S-1:0]     sel_slave;
    int unsigned      idx;

    // First requester at or after rr_ptr, wrapping modulo N.
    always_comb begin
        found     = 1'b0;
        sel       = '0;
        sel_slave = '0;
        idx       = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = (32'(rr_ptr_q) + i) % N;
            if (!found && req[idx]) begin
                found     = 1'b1;
                sel       = PTR_W'(idx);
                sel_slave = req_slave[idx*S +: S];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        slave_d   = slave_q;
        done_d    = '0;
        timeout_d = '0;
        start_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d    = START;
                    gnt_d      = '0;
                    gnt_d[sel] = 1'b1;
                    slave_d    = sel_slave;
                    start_d    = 1'b1;
                    rr_ptr_d   = PTR_W'((32'(sel) + 1) % N);
                    cnt_d      = '0;
                end
            end
            START: begin
                state_d = WAIT_DONE;
                cnt_d   = '0;
            end
            WAIT_DONE: begin
                // spi_done takes priority over a watchdog expiry in the same cycle.
                if (spi_done) begin
                    done_d  = gnt_q;
                    gnt_d   = '0;
                    slave_d = '0;
                    cnt_d   = '0;
                    state_d = GAP;
                end else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = gnt_q;
                    gnt_d     = '0;
                    slave_d   = '0;
                    cnt_d     = '0;
                    state_d   = GAP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            GAP: begin
                // The done/timeout pulse cycle counts as gap index 0.
                if (cnt_q == 16'(GAP_CYCLES)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            timeout_q <= '0;
            start_q   <= 1'b0;
            slave_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            start_q   <= start_d;
            slave_q   <= slave_d;
            busy_q    <= busy_d;
        end
    end

    assign gnt                   = gnt_q;
    assign done                  = done_q;
    assign timeout               = timeout_q;
    assign spi_start_transaction = start_q;
    assign spi_slave             = slave_q;
    assign busy                  = busy_q;

endmodule

// File: tb/tb_quick_spi_arbiter.sv
// Directed bench for quick_spi_arbiter: 4 clients, 2-bit slave index, 16-cycle watchdog, 2-cycle gap.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_quick_spi_arbiter;

    localparam int N = 4;
    localparam int S = 2;
    localparam int T = 16;
    localparam int G = 2;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*S-1:0] req_slave = '0;
    logic [N-1:0]   gnt, done, timeout;
    logic           spi_start_transaction;
    logic [S-1:0]   spi_slave;
    logic           spi_done = 1'b0;
    logic           busy;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    quick_spi_arbiter #(
        .NUMBER_OF_REQUESTERS(N),
        .NUMBER_OF_SLAVES(S),
        .TIMEOUT_CYCLES(T),
        .GAP_CYCLES(G)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .req(req),
        .req_slave(req_slave),
        .gnt(gnt),
        .done(done),
        .timeout(timeout),
        .spi_start_transaction(spi_start_transaction),
        .spi_slave(spi_slave),
        .spi_done(spi_done),
        .busy(busy)
    );

    task automatic apply_reset;
        @(negedge clk);
        reset_n  = 1'b0;
        req      = '0;
        spi_done = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Returns at the falling edge where the start pulse is visible, or ok=0 after 30 cycles.
    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (spi_start_transaction) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset_n = 1'b0;
        req     = 4'b1111;
        @(negedge clk);
        total++;
        if ({gnt, done, timeout, spi_start_transaction, spi_slave, busy} !== '0)
            $display("FAIL reset_outputs: got gnt=%b done=%b to=%b st=%b sl=%b busy=%b, want all 0",
                     gnt, done, timeout, spi_start_transaction, spi_slave, busy);
        else passed++;
        req     = '0;
        reset_n = 1'b1;
    endtask

    task automatic test_single;
        bit ok;
        apply_reset();
        req_slave = 8'b00_00_00_01;
        req       = 4'b0001;
        wait_start(ok);
        total++;
        if (!ok || gnt !== 4'b0001 || spi_slave !== 2'd1 || busy !== 1'b1)
            $display("FAIL single_grant: got ok=%0d gnt=%b slave=%0d busy=%b, want 1 0001 1 1", ok, gnt, spi_slave, busy);
        else passed++;
        req = '0;
        @(negedge clk);
        total++;
        if (spi_start_transaction !== 1'b0 || gnt !== 4'b0001)
            $display("FAIL single_start_pulse: got st=%b gnt=%b, want 0 0001", spi_start_transaction, gnt);
        else passed++;
        repeat (11) @(negedge clk);
        spi_done = 1'b1;
        @(negedge clk);
        spi_done = 1'b0;
        total++;
        if (done !== 4'b0001 || gnt !== 4'b0000 || spi_slave !== 2'd0 || timeout !== 4'b0000 || busy !== 1'b1)
            $display("FAIL single_done: got done=%b gnt=%b sl=%0d to=%b busy=%b, want 0001 0000 0 0000 1",
                     done, gnt, spi_slave, timeout, busy);
        else passed++;
        @(negedge clk);
        total++;
        if (done !== 4'b0000 || busy !== 1'b1)
            $display("FAIL single_gap1: got done=%b busy=%b, want 0000 1", done, busy);
        else passed++;
        @(negedge clk);
        total++;
        if (busy !== 1'b1) $display("FAIL single_gap2: got busy=%b, want 1", busy);
        else passed++;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) $display("FAIL single_idle: got busy=%b, want 0", busy);
        else passed++;
    endtask

    task automatic test_round_robin;
        bit ok;
        logic [N-1:0] exp;
        apply_reset();
        req_slave = {2'd3, 2'd2, 2'd1, 2'd0};
        req       = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            exp = 4'b0001 << (j % 4);
            wait_start(ok);
            total++;
            if (!ok || gnt !== exp || spi_slave !== 2'(j % 4))
                $display("FAIL rr_grant%0d: got ok=%0d gnt=%b slave=%0d, want 1 %b %0d", j, ok, gnt, spi_slave, exp, j % 4);
            else passed++;
            repeat (9) @(negedge clk);
            spi_done = 1'b1;
            @(negedge clk);
            spi_done = 1'b0;
            total++;
            if (done !== exp || timeout !== 4'b0000)
                $display("FAIL rr_done%0d: got done=%b to=%b, want %b 0000", j, done, timeout, exp);
            else passed++;
        end
        req = '0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_timeout;
        bit ok;
        apply_reset();
        req_slave = {2'd3, 2'd2, 2'd1, 2'd0};
        req       = 4'b0010;
        wait_start(ok);
        total++;
        if (!ok || gnt !== 4'b0010)
            $display("FAIL to_grant: got ok=%0d gnt=%b, want 1 0010", ok, gnt);
        else passed++;
        req = 4'b0110;
        repeat (16) @(negedge clk);
        total++;
        if (timeout !== 4'b0000 || gnt !== 4'b0010)
            $display("FAIL to_early: got to=%b gnt=%b, want 0000 0010", timeout, gnt);
        else passed++;
        @(negedge clk);
        total++;
        if (timeout !== 4'b0010 || done !== 4'b0000 || gnt !== 4'b0000)
            $display("FAIL to_pulse: got to=%b done=%b gnt=%b, want 0010 0000 0000", timeout, done, gnt);
        else passed++;
        @(negedge clk);
        total++;
        if (timeout !== 4'b0000) $display("FAIL to_one_cycle: got to=%b, want 0000", timeout);
        else passed++;
        wait_start(ok);
        total++;
        if (!ok || gnt !== 4'b0100 || spi_slave !== 2'd2)
            $display("FAIL to_next_grant: got ok=%0d gnt=%b slave=%0d, want 1 0100 2", ok, gnt, spi_slave);
        else passed++;
        req = '0;
        @(negedge clk);
        spi_done = 1'b1;
        @(negedge clk);
        spi_done = 1'b0;
        total++;
        if (done !== 4'b0100) $display("FAIL to_next_done: got done=%b, want 0100", done);
        else passed++;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_done_timeout_tie;
        bit ok;
        apply_reset();
        req = 4'b0001;
        wait_start(ok);
        req = '0;
        repeat (16) @(negedge clk);
        total++;
        if (!ok || gnt !== 4'b0001 || timeout !== 4'b0000)
            $display("FAIL tie_pre: got ok=%0d gnt=%b to=%b, want 1 0001 0000", ok, gnt, timeout);
        else passed++;
        spi_done = 1'b1;
        @(negedge clk);
        spi_done = 1'b0;
        total++;
        if (done !== 4'b0001 || timeout !== 4'b0000)
            $display("FAIL tie_done_wins: got done=%b to=%b, want 0001 0000", done, timeout);
        else passed++;
        @(negedge clk);
        total++;
        if (done !== 4'b0000 || timeout !== 4'b0000)
            $display("FAIL tie_after: got done=%b to=%b, want 0000 0000", done, timeout);
        else passed++;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_async_reset;
        bit ok;
        apply_reset();
        req_slave = {2'd3, 2'd2, 2'd1, 2'd0};
        req       = 4'b0100;
        wait_start(ok);
        total++;
        if (!ok || gnt !== 4'b0100)
            $display("FAIL ar_grant: got ok=%0d gnt=%b, want 1 0100", ok, gnt);
        else passed++;
        req = '0;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({gnt, done, timeout, spi_start_transaction, spi_slave, busy} !== '0)
            $display("FAIL ar_immediate: got gnt=%b done=%b to=%b st=%b sl=%b busy=%b, want all 0",
                     gnt, done, timeout, spi_start_transaction, spi_slave, busy);
        else passed++;
        @(negedge clk);
        reset_n = 1'b1;
        req     = 4'b1100;
        wait_start(ok);
        total++;
        if (!ok || gnt !== 4'b0100)
            $display("FAIL ar_rr_restart: got ok=%0d gnt=%b, want 1 0100", ok, gnt);
        else passed++;
        req = '0;
        @(negedge clk);
        spi_done = 1'b1;
        @(negedge clk);
        spi_done = 1'b0;
        total++;
        if (done !== 4'b0100) $display("FAIL ar_done: got done=%b, want 0100", done);
        else passed++;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_stray_done;
        bit ok;
        apply_reset();
        req_slave = {2'd3, 2'd2, 2'd1, 2'd0};
        req       = 4'b0001;
        wait_start(ok);
        repeat (2) @(negedge clk);
        req = '0;
        repeat (3) @(negedge clk);
        total++;
        if (!ok || gnt !== 4'b0001 || busy !== 1'b1)
            $display("FAIL stray_hold: got ok=%0d gnt=%b busy=%b, want 1 0001 1", ok, gnt, busy);
        else passed++;
        spi_done = 1'b1;
        @(negedge clk);
        total++;
        if (done !== 4'b0001) $display("FAIL stray_real_done: got done=%b, want 0001", done);
        else passed++;
        // held high one more cycle: this sample lands in GAP
        @(negedge clk);
        spi_done = 1'b0;
        total++;
        if (done !== 4'b0000 || timeout !== 4'b0000 || gnt !== 4'b0000)
            $display("FAIL stray_ignored: got done=%b to=%b gnt=%b, want 0000 0000 0000", done, timeout, gnt);
        else passed++;
        @(negedge clk);
        total++;
        if (done !== 4'b0000) $display("FAIL stray_after: got done=%b, want 0000", done);
        else passed++;
        repeat (2) @(negedge clk);
        total++;
        if (busy !== 1'b0 || spi_start_transaction !== 1'b0)
            $display("FAIL stray_idle: got busy=%b st=%b, want 0 0", busy, spi_start_transaction);
        else passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded its time limit, got no finish, want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_done_timeout_tie();
        test_async_reset();
        test_stray_done();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
